mux8b_arb: RTL and testbench
============================

MUX8B_ARB -- requirements
Module: mux8b_arb

Interface
REQ-001 The block SHALL have a single clock `clk`; reset `rst` SHALL be synchronous and active-high.
REQ-002 Port list, clock and reset first (name / direction / width / meaning):
- `clk` / in / 1 / rising-edge clock.
- `rst` / in / 1 / synchronous active-high reset.
- `a_data` / in / 8 / requester A payload.
- `a_valid` / in / 1 / A offers `a_data`.
- `a_ready` / out / 1 / A transfer accepted this cycle.
- `b_data` / in / 8 / requester B payload.
- `b_valid` / in / 1 / B offers `b_data`.
- `b_ready` / out / 1 / B transfer accepted this cycle.
- `f_data` / out / 8 / registered muxed payload.
- `f_valid` / out / 1 / `f_data` holds an unconsumed word.
- `f_src` / out / 1 / source of `f_data`: 0 = A, 1 = B.
- `f_ready` / in / 1 / downstream consumes `f_data` this cycle.
- `a_cnt` / out / 8 / words granted to A since reset.
- `b_cnt` / out / 8 / words granted to B since reset.
REQ-003 The block SHALL have no parameters; data width SHALL be fixed at 8 bits.

Function
REQ-004 A transfer on input X SHALL occur in a cycle where `X_valid` and `X_ready` are both high.
REQ-005 Output load enable SHALL be defined as `load = !f_valid | f_ready`.
REQ-006 `a_ready` and `b_ready` SHALL be combinational and asserted only when `load` is high and that input holds the grant.
- At most one ready SHALL be high per cycle.
- A ready SHALL never be high while its valid is low.
REQ-007 The grant SHALL select `Sel` of the `mux8b` instance (0 = A, 1 = B).
- The muxed word SHALL be registered into `f_data` on a transfer.
- `f_src` SHALL be set to `Sel`, and `f_valid` SHALL be set to 1.
REQ-008 Latency: a transfer in cycle t SHALL present `f_valid` = 1 with that word in cycle t+1.
REQ-009 Throughput: with `f_ready` held high, one word per cycle SHALL be sustained (back-to-back reload on consume).
REQ-010 If `f_ready` is high, `load` is high, and neither input is valid, `f_valid` SHALL clear next cycle.
REQ-011 While `f_valid` = 1 and `f_ready` = 0, the following SHALL all hold stable:
- `f_data`, `f_src`, `f_valid`.
- Both readys SHALL be 0.
REQ-012 State machine, registered:
- States: IDLE (`f_valid` = 0), HOLD_A (word from A), HOLD_B (word from B).
- Any state to HOLD_A / HOLD_B on a transfer from A / B.
- HOLD_x to IDLE on `f_ready` with no transfer.
- Otherwise the state SHALL be unchanged.
REQ-013 A `last` register SHALL record the most recently granted source (reset value 1, so A wins first).
REQ-014 Arbitration when both inputs are valid SHALL follow REQ-019 / REQ-020.
- When only one input is valid, that input SHALL be granted.
REQ-015 `a_cnt` / `b_cnt` SHALL increment by 1 per transfer of their source.
- They SHALL wrap from 255 to 0 silently.

Reset
REQ-016 When `rst` = 1 at a clock edge, the following SHALL be forced on that edge, overriding any concurrent transfer:
- State = IDLE.
- `f_valid` = 0, `f_data` = 8'h00, `f_src` = 0.
- `last` = 1.
- `a_cnt` = `b_cnt` = 0.
REQ-017 While `rst` = 1, `a_ready` and `b_ready` SHALL be 0.
- A word held mid-operation SHALL be discarded and SHALL not be counted.
REQ-018 The first transfer SHALL be possible in the first cycle after `rst` deasserts.

Configuration
REQ-019 With `MUX8B_ARB_RR_EN` defined, when both inputs are valid the grant SHALL go to the source opposite `last` (round-robin).
REQ-020 Without `MUX8B_ARB_RR_EN`, when both inputs are valid the grant SHALL always go to A (fixed priority).
- The `last` register SHALL be omitted or left unused.

Structure
REQ-021 A shared header SHALL define:
- State encodings IDLE = 2'd0, HOLD_A = 2'd1, HOLD_B = 2'd2.
- Source codes SRC_A = 1'b0, SRC_B = 1'b1.
REQ-022 The block SHALL instantiate the existing `mux8b` (F, A, B, Sel) as its sole sub-module for data selection.
- No other sub-module SHALL be used.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Reset: assert `rst` mid-hold with `f_valid` = 1 and counts nonzero -> next cycle all outputs 0, `a_ready` = `b_ready` = 0.
- Single source: `a_data` = 8'hAA, `a_valid` = 1, `f_ready` = 1 -> `a_ready` = 1 at t; `f_data` = 8'hAA, `f_src` = 0, `f_valid` = 1 at t+1; `a_cnt` = 1.
- Contention, RR build: A = 8'hAA and B = 8'h55 both valid, `f_ready` = 1, for 4 cycles -> `f_data` sequence AA,55,AA,55; `a_cnt` = `b_cnt` = 2. Fixed-priority build: AA x4, `b_ready` never high.
- Backpressure: `f_ready` = 0 with B = 8'h0F loaded -> `f_data` holds 0F, both readys 0 for 5 cycles; raise `f_ready` with A = 8'hF0 valid -> F0 next cycle.
- Drain: one word held, inputs idle, `f_ready` = 1 -> `f_valid` = 0 next cycle, state IDLE.
- Wrap: 256 A transfers -> `a_cnt` returns to 0.

Source files
------------

// File: rtl/mux8b_arb_pkg.sv
// Shared encodings for the mux8b_arb two-input arbitrated register slice.
package mux8b_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t HOLD_A = 2'd1;
    localparam state_t HOLD_B = 2'd2;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/mux8b.sv
// Plain 2:1 byte multiplexer used as the data-select path of mux8b_arb.
module mux8b (
    output logic [7:0] F,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Sel
);

    assign F = Sel ? B : A;

endmodule

// File: rtl/mux8b_arb.sv
// Two-requester arbiter feeding a one-word registered output slot.
// Optional MUX8B_ARB_RR_EN: round-robin on contention (default: A has fixed priority).
module mux8b_arb
    import mux8b_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a_data,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [7:0] b_data,
    input  logic       b_valid,
    output logic       b_ready,
    output logic [7:0] f_data,
    output logic       f_valid,
    output logic       f_src,
    input  logic       f_ready,
    output logic [7:0] a_cnt,
    output logic [7:0] b_cnt
);

    state_t     state_q, state_d;
    logic [7:0] f_data_q, f_data_d;
    logic       f_src_q, f_src_d;
    logic [7:0] a_cnt_q, a_cnt_d;
    logic [7:0] b_cnt_q, b_cnt_d;
`ifdef MUX8B_ARB_RR_EN
    logic       last_q, last_d;
`endif

    logic       sel;
    logic       load;
    logic       xfer;
    logic [7:0] mux_out;

    mux8b u_mux (
        .F   (mux_out),
        .A   (a_data),
        .B   (b_data),
        .Sel (sel)
    );

    always_comb begin
        sel = SRC_A;
        if (a_valid && b_valid) begin
`ifdef MUX8B_ARB_RR_EN
            sel = ~last_q;
`else
            sel = SRC_A;
`endif
        end else if (b_valid) begin
            sel = SRC_B;
        end
    end

    assign f_valid = (state_q != IDLE);
    assign load    = !f_valid || f_ready;
    // Readys are suppressed during reset so no word is accepted and then discarded uncounted.
    assign a_ready = !rst && load && a_valid && (sel == SRC_A);
    assign b_ready = !rst && load && b_valid && (sel == SRC_B);
    assign xfer    = a_ready || b_ready;

    always_comb begin
        state_d  = state_q;
        f_data_d = f_data_q;
        f_src_d  = f_src_q;
        a_cnt_d  = a_cnt_q;
        b_cnt_d  = b_cnt_q;
`ifdef MUX8B_ARB_RR_EN
        last_d   = last_q;
`endif
        if (xfer) begin
            f_data_d = mux_out;
            f_src_d  = sel;
            state_d  = (sel == SRC_B) ? HOLD_B : HOLD_A;
`ifdef MUX8B_ARB_RR_EN
            last_d   = sel;
`endif
            if (sel == SRC_B) begin
                b_cnt_d = b_cnt_q + 8'd1;
            end else begin
                a_cnt_d = a_cnt_q + 8'd1;
            end
        end else if (f_ready && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            f_data_q <= 8'h00;
            f_src_q  <= SRC_A;
            a_cnt_q  <= 8'd0;
            b_cnt_q  <= 8'd0;
`ifdef MUX8B_ARB_RR_EN
            last_q   <= SRC_B;
`endif
        end else begin
            state_q  <= state_d;
            f_data_q <= f_data_d;
            f_src_q  <= f_src_d;
            a_cnt_q  <= a_cnt_d;
            b_cnt_q  <= b_cnt_d;
`ifdef MUX8B_ARB_RR_EN
            last_q   <= last_d;
`endif
        end
    end

    assign f_data = f_data_q;
    assign f_src  = f_src_q;
    assign a_cnt  = a_cnt_q;
    assign b_cnt  = b_cnt_q;

endmodule

// File: tb/tb_mux8b_arb.sv
// Self-checking bench for mux8b_arb: vector table, directed corner sequences, random vs. reference model.
module tb_mux8b_arb;

`ifdef MUX8B_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid, f_ready;
    logic       a_ready, b_ready;
    logic [7:0] f_data;
    logic       f_valid, f_src;
    logic [7:0] a_cnt, b_cnt;

    always #5 clk = ~clk;

    mux8b_arb dut (
        .clk     (clk),
        .rst     (rst),
        .a_data  (a_data),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .b_data  (b_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .f_data  (f_data),
        .f_valid (f_valid),
        .f_src   (f_src),
        .f_ready (f_ready),
        .a_cnt   (a_cnt),
        .b_cnt   (b_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: a one-word slot plus per-source tallies.
    bit       m_full;
    bit [7:0] m_word;
    bit       m_src;
    int       m_na, m_nb;
    bit       m_last;
    bit       e_ar, e_br;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_full = 0; m_word = 8'h00; m_src = 0; m_na = 0; m_nb = 0; m_last = 1;
    endtask

    // One clock cycle: drive, check readys mid-cycle, advance model on the edge, check registered outputs.
    task automatic step(input bit r, input bit [7:0] ad, input bit av,
                        input bit [7:0] bd, input bit bv, input bit fr);
        bit winner;
        bit can_take;
        rst = r; a_data = ad; a_valid = av; b_data = bd; b_valid = bv; f_ready = fr;
        can_take = !m_full || fr;
        if (av && bv) winner = RR ? !m_last : 1'b0;
        else          winner = bv;
        e_ar = !r && can_take && av && (winner == 1'b0);
        e_br = !r && can_take && bv && (winner == 1'b1);
        @(negedge clk);
        chk("a_ready", a_ready, e_ar);
        chk("b_ready", b_ready, e_br);
        @(posedge clk);
        if (r) model_reset();
        else if (e_ar || e_br) begin
            m_full = 1; m_src = winner; m_last = winner;
            m_word = winner ? bd : ad;
            if (winner) m_nb++; else m_na++;
        end else if (fr) m_full = 0;
        #1;
        chk("f_valid", f_valid, m_full);
        chk("f_data",  f_data,  m_word);
        chk("f_src",   f_src,   m_src);
        chk("a_cnt",   a_cnt,   m_na % 256);
        chk("b_cnt",   b_cnt,   m_nb % 256);
    endtask

    typedef struct {
        bit       r;
        bit [7:0] ad;
        bit       av;
        bit [7:0] bd;
        bit       bv;
        bit       fr;
        bit       x_ar, x_br, x_fv;
        bit [7:0] x_fd;
        bit       x_fs;
        bit [7:0] x_ac, x_bc;
    } vec_t;

    vec_t vecs[9];
    int   b_hits;
    int   seq_i;

    initial begin
        rst = 1; a_data = 0; a_valid = 0; b_data = 0; b_valid = 0; f_ready = 0;
        model_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        //          r  ad    av bd    bv fr  ar br fv fd    fs ac bc
        vecs[0] = '{0, 8'hAA, 1, 8'h00, 0, 1, 1, 0, 1, 8'hAA, 0, 1, 0};
        vecs[1] = '{0, 8'h00, 0, 8'h55, 1, 0, 0, 0, 1, 8'hAA, 0, 1, 0};
        vecs[2] = '{0, 8'h00, 0, 8'h55, 1, 1, 0, 1, 1, 8'h55, 1, 1, 1};
        vecs[3] = '{0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 8'h55, 1, 1, 1};
        vecs[4] = '{0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h55, 1, 1, 1};
        vecs[5] = '{0, 8'h3C, 1, 8'h00, 0, 0, 1, 0, 1, 8'h3C, 0, 2, 1};
        vecs[6] = '{0, 8'h00, 0, 8'h81, 1, 1, 0, 1, 1, 8'h81, 1, 2, 2};
        vecs[7] = '{0, 8'h7E, 1, 8'h00, 0, 1, 1, 0, 1, 8'h7E, 0, 3, 2};
        vecs[8] = '{1, 8'h11, 1, 8'h22, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0};

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].r, vecs[i].ad, vecs[i].av, vecs[i].bd, vecs[i].bv, vecs[i].fr);
            chk($sformatf("vec%0d_a_ready", i), {31'd0, e_ar}, {31'd0, vecs[i].x_ar});
            chk($sformatf("vec%0d_b_ready", i), {31'd0, e_br}, {31'd0, vecs[i].x_br});
            chk($sformatf("vec%0d_f_valid", i), f_valid, vecs[i].x_fv);
            chk($sformatf("vec%0d_f_data", i),  f_data,  vecs[i].x_fd);
            chk($sformatf("vec%0d_f_src", i),   f_src,   vecs[i].x_fs);
            chk($sformatf("vec%0d_a_cnt", i),   a_cnt,   vecs[i].x_ac);
            chk($sformatf("vec%0d_b_cnt", i),   b_cnt,   vecs[i].x_bc);
        end

        // Contention: both valid, consumer always ready.
        step(1, 0, 0, 0, 0, 0);
        b_hits = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 8'hAA, 1, 8'h55, 1, 1);
            if (b_ready === 1'b1) b_hits++;
            if (RR) chk($sformatf("rr_seq%0d", i), f_data, (i % 2 == 0) ? 8'hAA : 8'h55);
            else    chk($sformatf("fp_seq%0d", i), f_data, 8'hAA);
        end
        chk("cont_a_cnt", a_cnt, RR ? 8'd2 : 8'd4);
        chk("cont_b_cnt", b_cnt, RR ? 8'd2 : 8'd0);
        chk("cont_b_ready_hits", b_hits, RR ? 2 : 0);

        // Backpressure: B word held while consumer stalls.
        step(1, 0, 0, 0, 0, 0);
        step(0, 8'h00, 0, 8'h0F, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 8'hF0, 1, 8'h0F, 1, 0);
            chk($sformatf("bp_hold%0d", i), f_data, 8'h0F);
            chk($sformatf("bp_rdy%0d", i), {a_ready, b_ready}, 2'b00);
            chk($sformatf("bp_src%0d", i), f_src, 1'b1);
        end
        step(0, 8'hF0, 1, 8'h00, 0, 1);
        chk("bp_release", f_data, 8'hF0);
        chk("bp_release_src", f_src, 1'b0);

        // Drain: held word consumed with nothing offered.
        step(0, 0, 0, 0, 0, 1);
        chk("drain_f_valid", f_valid, 1'b0);

        // Counter wrap after 256 A transfers.
        step(1, 0, 0, 0, 0, 0);
        for (seq_i = 0; seq_i < 256; seq_i++) begin
            step(0, seq_i[7:0], 1, 8'h00, 0, 1);
            if (seq_i == 254) chk("wrap_255", a_cnt, 8'd255);
        end
        chk("wrap_0", a_cnt, 8'd0);
        chk("wrap_last_word", f_data, 8'hFF);

        // Random traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(63) == 0), 8'($urandom), ($urandom_range(2) != 0),
                 8'($urandom), ($urandom_range(2) != 0), ($urandom_range(3) != 0));
            if (a_ready && b_ready) chk("one_hot_ready", 1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
